// File: rtl/axi_lite_regfile_core_if.sv
// axi_lite_regfile_core_if: AXI-Lite bus bundle between the shell (master) and the register block (slave)
// Carries the AW, W, B, AR and R channels; 32-bit address and data, 4-bit byte strobe, 2-bit responses.
interface axi_lite_regfile_core_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
  );
  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
  );
endinterface

// File: rtl/axi_lite_regfile_core.sv
// axi_lite_regfile_core: AXI-Lite slave with ID, LED, DIP, cycle counter and scratch registers
// Ports: clk, reset (sync, active-low), bus (AXI-Lite slave modport),
//        vdip (virtual DIP switches in), vled (registered LED value out).
module axi_lite_regfile_core #(
  parameter int          NUM_REGS = 8,
  parameter int          ADDR_W   = 12,
  parameter int          LED_W    = 16,
  parameter int          DIP_W    = 16,
  parameter logic [31:0] ID_VALUE = 32'h4857_0002
) (
  input  logic                      clk,
  input  logic                      reset,
  axi_lite_regfile_core_if.slave    bus,
  input  logic [DIP_W-1:0]          vdip,
  output logic [LED_W-1:0]          vled
);
  localparam int N_MAP = 4 + NUM_REGS;
  localparam logic [0:0] W_IDLE = 1'b0, W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0, R_RESP = 1'b1;
  logic [0:0]        ws_q, ws_d, rs_q, rs_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, waddr;
  logic [31:0]       wdata_q, wdata_d, wd;
  logic [3:0]        wstrb_q, wstrb_d, wsb;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d, rd_val;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DIP_W-1:0]  dip_q;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       scr_q [NUM_REGS];
  logic [31:0]       scr_d [NUM_REGS];
  logic              aw_hs, w_hs, ar_hs, commit, b_done;
  int                wi, ri;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
    return m;
  endfunction
  assign bus.awready = reset && ws_q == W_IDLE && !aw_held_q;
  assign bus.wready  = reset && ws_q == W_IDLE && !w_held_q;
  assign bus.bvalid  = reset && ws_q == W_RESP;
  assign bus.bresp   = bresp_q;
  assign bus.arready = reset && rs_q == R_IDLE;
  assign bus.rvalid  = reset && rs_q == R_RESP;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;
  assign vled        = led_q;
  always_comb begin
    aw_hs     = bus.awvalid && bus.awready;
    w_hs      = bus.wvalid && bus.wready;
    ar_hs     = bus.arvalid && bus.arready;
    b_done    = ws_q == W_RESP && bus.bready;
    // Commit as soon as both halves are present, whether held from earlier or handshaking now.
    commit    = ws_q == W_IDLE && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    waddr     = aw_held_q ? awaddr_q : bus.awaddr[ADDR_W-1:0];
    wd        = w_held_q ? wdata_q : bus.wdata;
    wsb       = w_held_q ? wstrb_q : bus.wstrb;
    wi        = int'(waddr[ADDR_W-1:2]);
    ri        = int'(bus.araddr[ADDR_W-1:2]);
    ws_d      = commit ? W_RESP : b_done ? W_IDLE : ws_q;
    aw_held_d = b_done ? 1'b0 : aw_held_q || aw_hs;
    w_held_d  = b_done ? 1'b0 : w_held_q || w_hs;
    awaddr_d  = aw_hs ? bus.awaddr[ADDR_W-1:0] : awaddr_q;
    wdata_d   = w_hs ? bus.wdata : wdata_q;
    wstrb_d   = w_hs ? bus.wstrb : wstrb_q;
    bresp_d   = commit ? (wi < N_MAP ? 2'b00 : 2'b10) : bresp_q;
    led_d     = (commit && wi == 1) ? LED_W'(merge(32'(led_q), wd, wsb)) : led_q;
    // A CNT write overrides the increment for that edge; counting resumes from the loaded value.
    cnt_d     = (commit && wi == 3) ? merge(cnt_q, wd, wsb) : cnt_q + 32'd1;
    scr_d     = scr_q;
    for (int i = 0; i < NUM_REGS; i++) if (commit && wi == i + 4) scr_d[i] = merge(scr_q[i], wd, wsb);
    rd_val    = ri == 0 ? ID_VALUE : ri == 1 ? 32'(led_q) : ri == 2 ? 32'(dip_q) : ri == 3 ? cnt_q : 32'hDEAD_BEEF;
    for (int i = 0; i < NUM_REGS; i++) if (ri == i + 4) rd_val = scr_q[i];
    rs_d      = ar_hs ? R_RESP : (rs_q == R_RESP && bus.rready) ? R_IDLE : rs_q;
    rdata_d   = ar_hs ? rd_val : rdata_q;
    rresp_d   = ar_hs ? (ri < N_MAP ? 2'b00 : 2'b10) : rresp_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      ws_q      <= W_IDLE;
      rs_q      <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      led_q     <= '0;
      dip_q     <= '0;
      cnt_q     <= '0;
      scr_q     <= '{default: '0};
    end else begin
      ws_q      <= ws_d;
      rs_q      <= rs_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      dip_q     <= vdip;
      cnt_q     <= cnt_d;
      scr_q     <= scr_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_regfile_core.sv
// tb_axi_lite_regfile_core: randomized AXI-Lite traffic checked against a register-map reference model
module tb_axi_lite_regfile_core;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] vdip = '0;
  logic [15:0] vled;
  int          cyc = 0;
  int          n_tests = 0, n_fail = 0;
  logic [15:0] led_m, dip_m;
  logic [31:0] scr_m [8];
  logic [31:0] cnt_base;
  int          cnt_cyc;
  axi_lite_regfile_core_if bus();
  axi_lite_regfile_core dut (.clk(clk), .reset(reset), .bus(bus), .vdip(vdip), .vled(vled));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
    return m;
  endfunction
  function automatic logic [31:0] cnt_at(input int c);
    return cnt_base + 32'(c - cnt_cyc);
  endfunction
  task automatic model_reset();
    led_m = '0;
    for (int i = 0; i < 8; i++) scr_m[i] = '0;
    cnt_base = '0;
    cnt_cyc = cyc;
  endtask
  task automatic model_read(input logic [31:0] a, input int c, output logic [31:0] d, output logic [1:0] r);
    int idx;
    idx = int'(a[11:2]);
    r = 2'b00;
    if (idx == 0) d = 32'h4857_0002;
    else if (idx == 1) d = {16'h0, led_m};
    else if (idx == 2) d = {16'h0, dip_m};
    else if (idx == 3) d = cnt_at(c);
    else if (idx < 12) d = scr_m[idx-4];
    else begin
      d = 32'hDEAD_BEEF;
      r = 2'b10;
    end
  endtask
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int c, output logic [1:0] r);
    int idx;
    idx = int'(a[11:2]);
    r = idx < 12 ? 2'b00 : 2'b10;
    if (idx == 1) led_m = 16'(mrg({16'h0, led_m}, d, s));
    else if (idx == 3) begin
      cnt_base = mrg(cnt_at(c), d, s);
      cnt_cyc = c + 1;
    end else if (idx >= 4 && idx < 12) scr_m[idx-4] = mrg(scr_m[idx-4], d, s);
  endtask
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int ad, input int wd, input int bd);
    int k = 0, c = 0;
    bit a_done = 0, w_done = 0;
    logic [1:0] er;
    while (!(a_done && w_done)) begin
      @(negedge clk);
      bus.awvalid = !a_done && k >= ad;
      bus.awaddr  = a;
      bus.wvalid  = !w_done && k >= wd;
      bus.wdata   = d;
      bus.wstrb   = s;
      #1;
      if (a_done) check("awready_held", 32'(bus.awready), 0);
      if (w_done) check("wready_held", 32'(bus.wready), 0);
      if (bus.awvalid && bus.awready) a_done = 1;
      if (bus.wvalid && bus.wready) w_done = 1;
      c = cyc;
      k++;
      if (k > 40) begin
        check("wr_timeout", 0, 1);
        break;
      end
    end
    model_write(a, d, s, c, er);
    @(posedge clk);
    #1;
    check("bvalid", 32'(bus.bvalid), 1);
    check("bresp", 32'(bus.bresp), 32'(er));
    check("vled", 32'(vled), 32'(led_m));
    @(negedge clk);
    bus.awvalid = 0;
    bus.wvalid  = 0;
    for (int i = 0; i < bd; i++) begin
      #1;
      check("bvalid_stall", 32'(bus.bvalid), 1);
      check("bresp_stall", 32'(bus.bresp), 32'(er));
      check("aw_w_ready_stall", {bus.awready, bus.wready}, 0);
      @(negedge clk);
    end
    bus.bready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.bready = 0;
    #1;
    check("bvalid_clear", 32'(bus.bvalid), 0);
  endtask
  task automatic do_read(input logic [31:0] a, input int rd, output logic [31:0] got, output int c);
    int k = 0;
    logic [31:0] ed;
    logic [1:0] er;
    c = 0;
    forever begin
      @(negedge clk);
      bus.arvalid = 1;
      bus.araddr  = a;
      #1;
      c = cyc;
      if (bus.arready) break;
      k++;
      if (k > 40) begin
        check("rd_timeout", 0, 1);
        break;
      end
    end
    model_read(a, c, ed, er);
    @(posedge clk);
    #1;
    got = bus.rdata;
    check("rvalid", 32'(bus.rvalid), 1);
    check("rdata", bus.rdata, ed);
    check("rresp", 32'(bus.rresp), 32'(er));
    @(negedge clk);
    bus.arvalid = 0;
    for (int i = 0; i < rd; i++) begin
      #1;
      check("rvalid_stall", 32'(bus.rvalid), 1);
      check("rdata_stall", bus.rdata, ed);
      @(negedge clk);
    end
    bus.rready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.rready = 0;
    #1;
    check("rvalid_clear", 32'(bus.rvalid), 0);
  endtask
  initial begin
    logic [31:0] g1, g2, a;
    int c1, c2;
    bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
    dip_m = 16'h3C5A;
    vdip = dip_m;
    repeat (3) @(negedge clk);
    #1;
    check("rst_readies", {bus.awready, bus.wready, bus.arready}, 0);
    check("rst_valids", {bus.bvalid, bus.rvalid}, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_vled", 32'(vled), 0);
    @(negedge clk);
    reset = 1;
    model_reset();
    #1;
    check("ready_after_rst", {bus.awready, bus.wready, bus.arready}, 3'b111);
    do_read(32'h0, 0, g1, c1);
    do_write(32'h4, 32'h0000_A5A5, 4'b0011, 0, 0, 0);
    do_read(32'h4, 0, g1, c1);
    check("led_lit", g1, 32'h0000_A5A5);
    do_write(32'h18, 32'h1234_5678, 4'b0101, 3, 0, 0);
    do_read(32'h18, 1, g1, c1);
    check("scr2_lit", g1, 32'h0034_0078);
    do_read(32'h8, 0, g1, c1);
    do_read(32'h30, 0, g1, c1);
    do_write(32'h30, 32'hFFFF_FFFF, 4'hF, 0, 2, 0);
    do_read(32'h4, 0, g1, c1);
    do_read(32'h18, 0, g1, c1);
    do_write(32'hC, 32'hFFFF_FFFE, 4'hF, 0, 0, 0);
    do_read(32'hC, 0, g1, c1);
    do_read(32'hC, 0, g2, c2);
    check("cnt_delta", g2 - g1, 32'(c2 - c1));
    fork
      do_write(32'h14, 32'hCAFE_F00D, 4'hF, 0, 0, 5);
      begin
        @(negedge clk);
        do_read(32'h0, 0, g1, c1);
        do_read(32'h14, 0, g1, c1);
      end
    join
    @(negedge clk);
    bus.awvalid = 1; bus.awaddr = 32'h1C; bus.wvalid = 1; bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF;
    @(posedge clk);
    #1;
    check("pre_rst_bvalid", 32'(bus.bvalid), 1);
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0;
    reset = 0;
    #1;
    check("mid_rst_valids", {bus.bvalid, bus.rvalid}, 0);
    @(posedge clk);
    #1;
    check("mid_rst_valids2", {bus.bvalid, bus.rvalid}, 0);
    check("mid_rst_vled", 32'(vled), 0);
    @(negedge clk);
    reset = 1;
    model_reset();
    do_read(32'h1C, 0, g1, c1);
    do_read(32'hC, 0, g1, c1);
    for (int it = 0; it < 80; it++) begin
      @(negedge clk);
      dip_m = 16'($urandom);
      vdip = dip_m;
      a = ($urandom_range(0, 3) == 0 ? ($urandom & 32'hFFFF_F000) : 32'h0) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2), g1, c1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
